// File: rtl/bram_port_server_if.sv
// bram_port_server_if: valid/ready request and response bundle for bram_port_server
interface bram_port_server_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int WE_WIDTH = 1
);
  logic REQ_VALID;
  logic REQ_READY;
  logic [WE_WIDTH-1:0] REQ_WE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_DATA;
  logic RSP_VALID;
  logic RSP_READY;
  logic [DATA_WIDTH-1:0] RSP_DATA;
  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, RSP_READY,
    input REQ_READY, RSP_VALID, RSP_DATA
  );
  modport slave (
    input REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_DATA
  );
endinterface

// File: rtl/bram_port_server.sv
// bram_port_server: credit-gated BRAM port front-end with response FIFO; define BRAM_PORT_SERVER_BYPASS_EN for empty-FIFO same-cycle bypass
module bram_port_server #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int CHUNKSIZE = 1,
  parameter int WE_WIDTH = 1,
  parameter int PIPELINED = 0,
  parameter int RESP_DEPTH = 4,
  parameter int RESP_ON_WRITE = 0
) (
  input  logic CLK,
  input  logic RST_N,
  bram_port_server_if.slave bus,
  output logic BRAM_EN,
  output logic [WE_WIDTH-1:0] BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);
  localparam int L = PIPELINED ? 2 : 1;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1) + 1;
  if (DATA_WIDTH != CHUNKSIZE * WE_WIDTH) begin : g_cfg_check
    $error("DATA_WIDTH must equal CHUNKSIZE*WE_WIDTH");
  end
  logic accept, need, tag_out, push, pop, empty;
  logic [L-1:0] tags;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count, outstanding;
  logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
  assign accept = bus.REQ_VALID & bus.REQ_READY;
  assign need = (bus.REQ_WE == '0) | (RESP_ON_WRITE != 0);
  assign BRAM_EN = accept;
  assign BRAM_WE = bus.REQ_WE & {WE_WIDTH{accept}};
  assign BRAM_ADDR = bus.REQ_ADDR;
  assign BRAM_DI = bus.REQ_DATA;
  assign tag_out = tags[L-1];
  assign empty = count == '0;
  // every in-flight read already owns a FIFO slot, so returning data can never overflow
  always_comb begin
    outstanding = count;
    for (int i = 0; i < L; i++) outstanding = outstanding + CW'(tags[i]);
  end
  assign bus.REQ_READY = (outstanding < CW'(RESP_DEPTH)) & RST_N;
`ifdef BRAM_PORT_SERVER_BYPASS_EN
  assign bus.RSP_VALID = !empty | tag_out;
  assign bus.RSP_DATA = empty ? BRAM_DO : mem[rp];
  assign push = tag_out & !(empty & bus.RSP_READY);
`else
  assign bus.RSP_VALID = !empty;
  assign bus.RSP_DATA = mem[rp];
  assign push = tag_out;
`endif
  assign pop = !empty & bus.RSP_READY;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tags <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      tags <= (tags << 1) | L'(accept & need);
      if (push) wp <= (wp == PW'(RESP_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PW'(RESP_DEPTH - 1)) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge CLK) if (push) mem[wp] <= BRAM_DO;
endmodule
